// File: rtl/information_reader.sv
// Access-controlled register reader.
// A session opens while request is high; a confirm rising edge checks key against
// password. Once access is granted, each further confirm edge reads register P or Q
// (key[7] selects) and hands the word downstream with a valid/ready handshake.
// Optional feature macro: INFO_READER_LOCKOUT_EN. When it is defined, the third
// consecutive failure locks the block until reset_n is asserted.
module information_reader (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       request,
  input  logic       confirm,
  input  logic [7:0] password,
  input  logic [7:0] key,
  input  logic [7:0] regP_data,
  input  logic [7:0] regQ_data,
  input  logic       out_ready,
  output logic       readRegP,
  output logic       readRegQ,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       error,
  output logic       locked
);

  typedef enum logic [2:0] {
    StIdle,
    StActive,
    StGranted,
    StDenied,
    StRead,
    StCapture,
    StSend
`ifdef INFO_READER_LOCKOUT_EN
    , StLocked
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  fail_q, fail_d;
  logic        conf_q;
  logic        run_q;
  logic        sel_q, sel_d;
  logic [7:0]  dout_q, dout_d;
  logic        read_p_q, read_p_d;
  logic        read_q_q, read_q_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        conf_edge;
  logic [1:0]  fail_inc;
  logic        in_lock;
  logic        lock_next;

  assign conf_edge = confirm & ~conf_q;
  assign fail_inc  = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;

`ifdef INFO_READER_LOCKOUT_EN
  logic locked_q;
  assign in_lock   = (state_q == StLocked);
  assign lock_next = (state_d == StLocked);
  assign locked    = locked_q;
`else
  assign in_lock   = 1'b0;
  assign lock_next = 1'b0;
  assign locked    = 1'b0;
`endif

  // Next-state, session bookkeeping and Moore output decode from the next state.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    // run_q low for one edge after reset release keeps the FSM still on that edge.
    if (!run_q) begin
      state_d = state_q;
    end else if (state_q == StIdle) begin
      if (request) state_d = StActive;
    end else if (in_lock) begin
      state_d = state_q;
    end else if (!request) begin
      // Dropping request closes the session and discards any word in flight.
      state_d = StIdle;
    end else begin
      case (state_q)
        StActive: begin
          if (conf_edge) begin
            if (key == password) begin
              state_d = StGranted;
              fail_d  = 2'd0;
            end else begin
              fail_d  = fail_inc;
              state_d = StDenied;
`ifdef INFO_READER_LOCKOUT_EN
              if (fail_inc == 2'd3) state_d = StLocked;
`endif
            end
          end
        end
        StGranted: begin
          if (conf_edge) begin
            state_d = StRead;
            sel_d   = key[7];
          end
        end
        StRead:    state_d = StCapture;
        StCapture: begin
          dout_d  = sel_q ? regQ_data : regP_data;
          state_d = StSend;
        end
        StSend: begin
          if (out_ready) state_d = StGranted;
        end
        default: state_d = state_q;
      endcase
    end

    read_p_d = (state_d == StRead) && !sel_d;
    read_q_d = (state_d == StRead) && sel_d;
    valid_d  = (state_d == StSend);
    error_d  = (state_d == StDenied) || lock_next;
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      fail_q   <= 2'd0;
      conf_q   <= 1'b0;
      run_q    <= 1'b0;
      sel_q    <= 1'b0;
      dout_q   <= 8'h00;
      read_p_q <= 1'b0;
      read_q_q <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      conf_q   <= confirm;
      run_q    <= 1'b1;
      sel_q    <= sel_d;
      dout_q   <= dout_d;
      read_p_q <= read_p_d;
      read_q_q <= read_q_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

`ifdef INFO_READER_LOCKOUT_EN
  // Lock indicator, registered alongside the other outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) locked_q <= 1'b0;
    else          locked_q <= lock_next;
  end
`endif

  assign readRegP   = read_p_q;
  assign readRegQ   = read_q_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign error      = error_q;

endmodule

// File: tb/tb_information_reader.sv
// Bench for information_reader: directed vector table, hand-written corner sequences
// and randomized stimulus against a session-level reference model.
module tb_information_reader;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       request = 1'b0;
  logic       confirm = 1'b0;
  logic [7:0] password = 8'h5A;
  logic [7:0] key = 8'h00;
  logic [7:0] regP_data = 8'hA5;
  logic [7:0] regQ_data = 8'h3C;
  logic       out_ready = 1'b0;
  logic       readRegP, readRegQ, data_valid, error, locked;
  logic [7:0] data_out;

  int errors = 0;
  int checks = 0;

`ifdef INFO_READER_LOCKOUT_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  information_reader dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .request   (request),
    .confirm   (confirm),
    .password  (password),
    .key       (key),
    .regP_data (regP_data),
    .regQ_data (regQ_data),
    .out_ready (out_ready),
    .readRegP  (readRegP),
    .readRegQ  (readRegQ),
    .data_out  (data_out),
    .data_valid(data_valid),
    .error     (error),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  // Reference model: session phase plus a read-pipeline stage counter.
  // sess: 0 closed, 1 awaiting code, 2 access granted, 3 refused, 4 locked out.
  // stage (only while granted): 0 none, 1 strobe, 2 capture, 3 offering word.
  int         m_sess, m_stage, m_fail;
  bit         m_ready, m_conf_prev, m_sel;
  logic [7:0] m_dout;

  task automatic model_reset();
    m_sess = 0; m_stage = 0; m_fail = 0;
    m_ready = 0; m_conf_prev = 0; m_sel = 0; m_dout = 8'h00;
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen = confirm && !m_conf_prev;
    m_conf_prev = confirm;
    if (!m_ready) begin
      m_ready = 1;
      return;
    end
    if (m_sess == 4) return;
    if (m_sess == 0) begin
      if (request) m_sess = 1;
      return;
    end
    if (!request) begin
      m_sess = 0; m_stage = 0;
      return;
    end
    if (m_sess == 1 && edge_seen) begin
      if (key == password) begin
        m_sess = 2; m_fail = 0;
      end else begin
        m_fail = (m_fail >= 3) ? 3 : m_fail + 1;
        m_sess = (LockEn && m_fail == 3) ? 4 : 3;
      end
    end else if (m_sess == 2) begin
      if (m_stage == 0) begin
        if (edge_seen) begin m_stage = 1; m_sel = key[7]; end
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (m_stage == 2) begin
        m_dout = m_sel ? regQ_data : regP_data;
        m_stage = 3;
      end else if (out_ready) begin
        m_stage = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: the model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    bit granted;
    granted = (m_sess == 2);
    chk({tag, " readRegP"},   {7'd0, readRegP},   {7'd0, granted && m_stage == 1 && !m_sel});
    chk({tag, " readRegQ"},   {7'd0, readRegQ},   {7'd0, granted && m_stage == 1 && m_sel});
    chk({tag, " data_valid"}, {7'd0, data_valid}, {7'd0, granted && m_stage == 3});
    chk({tag, " error"},      {7'd0, error},      {7'd0, m_sess >= 3});
    chk({tag, " locked"},     {7'd0, locked},     {7'd0, m_sess == 4});
    chk({tag, " data_out"},   data_out,           m_dout);
  endtask

  // Called at posedge+1; returns at posedge+4 with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    model_reset();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       req, conf, rdy;
    logic [7:0] key;
    logic       rp, rq, dv, err;
    logic [7:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic conf, input logic [7:0] k,
                              input logic rdy, input logic rp, input logic rq,
                              input logic dv, input logic err, input logic [7:0] dout);
    vec_t v;
    v.req = req; v.conf = conf; v.key = k; v.rdy = rdy;
    v.rp = rp; v.rq = rq; v.dv = dv; v.err = err; v.dout = dout;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(1, 0, 8'h5A, 0, 0, 0, 0, 0, 8'h00); // IDLE -> ACTIVE
    tbl[1]  = mk(1, 1, 8'h5A, 0, 0, 0, 0, 0, 8'h00); // correct code -> GRANTED
    tbl[2]  = mk(1, 0, 8'h80, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = mk(1, 1, 8'h80, 0, 0, 1, 0, 0, 8'h00); // read Q strobe
    tbl[4]  = mk(1, 0, 8'h80, 0, 0, 0, 0, 0, 8'h00); // capture
    tbl[5]  = mk(1, 0, 8'h80, 0, 0, 0, 1, 0, 8'h3C); // valid 3 cycles after edge
    tbl[6]  = mk(1, 0, 8'h80, 0, 0, 0, 1, 0, 8'h3C);
    tbl[7]  = mk(1, 0, 8'h80, 0, 0, 0, 1, 0, 8'h3C);
    tbl[8]  = mk(1, 0, 8'h80, 0, 0, 0, 1, 0, 8'h3C);
    tbl[9]  = mk(1, 0, 8'h80, 0, 0, 0, 1, 0, 8'h3C);
    tbl[10] = mk(1, 0, 8'h80, 1, 0, 0, 0, 0, 8'h3C); // accepted -> GRANTED
    tbl[11] = mk(0, 0, 8'h11, 0, 0, 0, 0, 0, 8'h3C); // close session
    tbl[12] = mk(1, 0, 8'h11, 0, 0, 0, 0, 0, 8'h3C);
    tbl[13] = mk(1, 1, 8'h11, 0, 0, 0, 0, 1, 8'h3C); // wrong code -> DENIED
    tbl[14] = mk(1, 0, 8'h11, 0, 0, 0, 0, 1, 8'h3C);
    tbl[15] = mk(1, 1, 8'h5A, 0, 0, 0, 0, 1, 8'h3C); // edges ignored in DENIED
    tbl[16] = mk(0, 0, 8'h5A, 0, 0, 0, 0, 0, 8'h3C); // request low -> IDLE

    model_reset();
    #2;
    chk("reset readRegP", {7'd0, readRegP}, 8'd0);
    chk("reset data_out", data_out, 8'h00);
    chk("reset error", {7'd0, error}, 8'd0);
    @(posedge clock); #1;
    do_reset();
    tick(); tick();

    // Directed table.
    foreach (tbl[i]) begin
      request = tbl[i].req; confirm = tbl[i].conf; key = tbl[i].key; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d readRegP", i), {7'd0, readRegP}, {7'd0, tbl[i].rp});
      chk($sformatf("vec%0d readRegQ", i), {7'd0, readRegQ}, {7'd0, tbl[i].rq});
      chk($sformatf("vec%0d data_valid", i), {7'd0, data_valid}, {7'd0, tbl[i].dv});
      chk($sformatf("vec%0d error", i), {7'd0, error}, {7'd0, tbl[i].err});
      chk($sformatf("vec%0d locked", i), {7'd0, locked}, 8'd0);
      chk($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
    end

    // Abort in CAPTURE with simultaneous out_ready and confirm edge.
    request = 1; confirm = 0; key = 8'h5A; tick();
    confirm = 1; tick();
    confirm = 0; key = 8'h00; tick();
    confirm = 1; tick();
    chk("abort readRegP", {7'd0, readRegP}, 8'd1);
    chk("abort readRegQ", {7'd0, readRegQ}, 8'd0);
    confirm = 0; tick();
    request = 0; confirm = 1; out_ready = 1; tick();
    for (int i = 0; i < 3; i++) begin
      chk("abort data_valid", {7'd0, data_valid}, 8'd0);
      chk("abort data_out kept", data_out, 8'h3C);
      confirm = 0; out_ready = 0; tick();
    end

    // Reset asserted during READ drops the strobe at once.
    request = 1; key = 8'h5A; tick();
    confirm = 1; tick();
    confirm = 0; key = 8'h80; tick();
    confirm = 1; tick();
    chk("pre-reset readRegQ", {7'd0, readRegQ}, 8'd1);
    reset_n = 1'b0;
    #1;
    chk("async readRegQ", {7'd0, readRegQ}, 8'd0);
    chk("async readRegP", {7'd0, readRegP}, 8'd0);
    chk("async data_out", data_out, 8'h00);
    chk("async data_valid", {7'd0, data_valid}, 8'd0);
    #2;
    model_reset();
    // Release with request high: the FSM must wait an extra edge, so a confirm edge on
    // the second edge lands in IDLE and is lost.
    request = 1; confirm = 0; key = 8'h5A;
    reset_n = 1'b1;
    tick();
    confirm = 1; tick(); tick();
    confirm = 0; tick();
    confirm = 1; key = 8'h80; tick();
    chk("sync release error", {7'd0, error}, 8'd1);
    chk("sync release readRegQ", {7'd0, readRegQ}, 8'd0);
    request = 0; confirm = 0; tick();

`ifdef INFO_READER_LOCKOUT_EN
    do_reset(); tick(); tick();
    for (int s = 0; s < 3; s++) begin
      request = 1; confirm = 0; key = 8'h11; tick();
      confirm = 1; tick();
      request = 0; confirm = 0; if (s < 2) tick();
    end
    chk("lock locked", {7'd0, locked}, 8'd1);
    chk("lock error", {7'd0, error}, 8'd1);
    tick();
    request = 1; key = 8'h5A; tick();
    confirm = 1; tick(); tick();
    chk("lock holds locked", {7'd0, locked}, 8'd1);
    chk("lock holds readRegP", {7'd0, readRegP}, 8'd0);
    request = 0; confirm = 0;
    reset_n = 1'b0;
    #1;
    chk("unlock locked", {7'd0, locked}, 8'd0);
    chk("unlock error", {7'd0, error}, 8'd0);
    chk("unlock data_valid", {7'd0, data_valid}, 8'd0);
    #2;
    model_reset();
    reset_n = 1'b1;
    tick();
`endif

    // Randomized run against the model.
    do_reset(); tick();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        password = 8'($urandom);
        do_reset();
      end
      request   = ($urandom_range(0, 15) != 0);
      confirm   = $urandom_range(0, 1) == 1;
      key       = ($urandom_range(0, 1) == 1) ? password : 8'($urandom);
      if ($urandom_range(0, 3) == 0) key[7] = ~key[7];
      out_ready = ($urandom_range(0, 9) < 3);
      regP_data = 8'($urandom);
      regQ_data = 8'($urandom);
      tick();
      check_model($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/information_reader.md
INFORMATION_READER -- requirements
Module: information_reader

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 request  input  1  level; session open while high.
REQ-004 confirm  input  1  level; only its rising edge (confirm high, previous-cycle sample low) is acted on.
REQ-005 password  input  8  stored access code.
REQ-006 key  input  8  user-entered code; key[7] also selects the register (1 = Q, 0 = P) in read requests.
REQ-007 regP_data  input  8  current contents of register P, valid the cycle after readRegP.
REQ-008 regQ_data  input  8  current contents of register Q, valid the cycle after readRegQ.
REQ-009 out_ready  input  1  downstream accepts data_out when high with data_valid.
REQ-010 readRegP  output  1  one-cycle read strobe to register P.
REQ-011 readRegQ  output  1  one-cycle read strobe to register Q.
REQ-012 data_out  output  8  captured register value.
REQ-013 data_valid  output  1  data_out holds an unaccepted word.
REQ-014 error  output  1  high in DENIED and LOCKED.
REQ-015 locked  output  1  high in LOCKED.

Function
REQ-016 States: IDLE, ACTIVE, GRANTED, DENIED, READ, CAPTURE, SEND, LOCKED; outputs registered, Moore-style.
REQ-017 IDLE: request high -> ACTIVE next cycle; otherwise hold.
REQ-018 In every state except IDLE and LOCKED, request low -> IDLE next cycle; this dominates any simultaneous confirm edge or out_ready.
REQ-019 ACTIVE: confirm edge with key == password -> GRANTED, fail_cnt cleared; confirm edge with key != password -> DENIED, fail_cnt incremented (2 bits, saturating at 3).
REQ-020 GRANTED: confirm edge -> READ; key[7] sampled that cycle selects Q (1) or P (0).
REQ-021 READ: exactly one of readRegP/readRegQ high for this single cycle -> CAPTURE.
REQ-022 CAPTURE: data_out loaded from the selected regX_data -> SEND; readReg strobes low.
REQ-023 SEND: data_valid high, data_out stable; out_ready high -> transfer completes that edge, GRANTED next cycle with data_valid low.
REQ-024 Request low during READ/CAPTURE/SEND aborts: word discarded, data_valid low next cycle, data_out retains last value.
REQ-025 DENIED: error high; confirm edges ignored; exit only via request low.
REQ-026 Confirm edge detector register resets to 0, so confirm already high at leaving reset does not count as an edge.
REQ-027 Read latency: confirm edge in GRANTED to data_valid high = 3 cycles.

Reset
REQ-028 reset_n low asynchronously forces IDLE, fail_cnt = 0, confirm sample = 0, data_out = 8'h00, data_valid/readRegP/readRegQ/error/locked = 0.
REQ-029 Reset mid-session (any state, including LOCKED) takes effect immediately; no read strobe may remain high.
REQ-030 Release of reset_n is synchronised to clock; first transition possible on the second rising edge after release.

Configuration
REQ-031 Macro INFO_READER_LOCKOUT_EN defined: a failure that brings fail_cnt to 3 enters LOCKED instead of DENIED; LOCKED holds error = locked = 1, ignores request/confirm, and exits only via reset_n.
REQ-032 Macro undefined: LOCKED state absent, locked tied 0, failures always go to DENIED; fail_cnt still maintained.

Verification
REQ-033 password=8'h5A, request=1, key=8'h5A, confirm edge -> GRANTED, error=0; key=8'h80, confirm edge -> readRegQ high 1 cycle, regQ_data=8'h3C captured, data_valid=1 with data_out=8'h3C 3 cycles after edge.
REQ-034 In SEND hold out_ready=0 for 5 cycles -> data_valid and data_out=8'h3C stable; out_ready=1 -> data_valid=0 next cycle, state GRANTED.
REQ-035 key=8'h11 vs password=8'h5A, confirm edge -> error=1; drop request -> IDLE, error=0 next cycle.
REQ-036 INFO_READER_LOCKOUT_EN defined, three wrong sessions in a row -> locked=1; correct key afterwards ignored; reset_n pulse -> locked=0, all outputs at reset values.
REQ-037 Request low in CAPTURE with out_ready=1 and simultaneous confirm edge -> IDLE, data_valid never asserted; reset_n asserted during READ -> readRegP/readRegQ low immediately.
